// File: rtl/mini_core_accel_cr_mem_param.sv
// Control-register window between the mini_core data port and NUM_CH multiplier
// accelerators: operand latches, per-channel IDLE/BUSY/DONE sequencing, sticky error, IRQ.
module mini_core_accel_cr_mem_param #(
    parameter int          NUM_CH    = 8,
    parameter int          OP_W      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h00FE_2000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [31:0]                data,
    input  logic [31:0]                address,
    input  logic                       wren,
    input  logic                       rden,
    output logic [31:0]                q,
    output logic [NUM_CH*OP_W-1:0]     ch_multiplicand,
    output logic [NUM_CH*OP_W-1:0]     ch_multiplier,
    output logic [NUM_CH-1:0]          ch_start,
    input  logic [NUM_CH-1:0]          ch_done,
    input  logic [NUM_CH*2*OP_W-1:0]   ch_result,
    output logic                       irq
);

    localparam int          RES_W  = 2 * OP_W;
    localparam logic [11:0] CH_END = 12'(NUM_CH * 16);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    logic        hit;
    logic [11:0] off;
    logic [5:0]  chSel;
    logic [1:0]  regSel;
    logic        chHit, irqEnHit, doneSumHit, debugHit;
    logic        wrMcand, wrMplier, startReq, clrErr, rdResult;

    ch_state_e         state_q  [NUM_CH];
    ch_state_e         state_d  [NUM_CH];
    logic [OP_W-1:0]   mcand_q  [NUM_CH];
    logic [OP_W-1:0]   mcand_d  [NUM_CH];
    logic [OP_W-1:0]   mplier_q [NUM_CH];
    logic [OP_W-1:0]   mplier_d [NUM_CH];
    logic [RES_W-1:0]  result_q [NUM_CH];
    logic [RES_W-1:0]  result_d [NUM_CH];
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] start_q, start_d;
    logic [NUM_CH-1:0] irqEn_q, irqEn_d;
    logic [NUM_CH-1:0] chOh, doneVec;
    logic [31:0]       debug_q, debug_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       chRd, irqEnRd, doneRd;

    assign hit        = (address[31:12] == BASE_ADDR[31:12]);
    assign off        = address[11:0];
    assign chSel      = off[9:4];
    assign regSel     = off[3:2];
    assign chHit      = hit && (off < CH_END);
    assign irqEnHit   = hit && (off[11:2] == 10'h200);
    assign doneSumHit = hit && (off[11:2] == 10'h201);
    assign debugHit   = hit && (off[11:2] == 10'h202);

    assign wrMcand  = wren && chHit && (regSel == 2'd0);
    assign wrMplier = wren && chHit && (regSel == 2'd1);
    assign startReq = wren && chHit && (regSel == 2'd2) && data[0];
    assign clrErr   = wren && chHit && (regSel == 2'd2) && data[1];
    assign rdResult = rden && chHit && (regSel == 2'd3);

    always_comb begin
        chOh    = '0;
        doneVec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chOh[i]    = chHit && (chSel == 6'(i));
            doneVec[i] = (state_q[i] == ST_DONE);
        end
    end

    // Per-channel sequencing; an accelerator completion in BUSY outranks a same-cycle start.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            err_d[i]    = err_q[i];
            start_d[i]  = 1'b0;
            mcand_d[i]  = mcand_q[i];
            mplier_d[i] = mplier_q[i];
            result_d[i] = result_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (chOh[i] && startReq) begin
                        state_d[i] = ST_BUSY;
                        start_d[i] = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (ch_done[i]) begin
                        state_d[i]  = ST_DONE;
                        result_d[i] = ch_result[i*RES_W +: RES_W];
                    end
                    if (chOh[i] && (startReq || wrMcand || wrMplier)) begin
                        err_d[i] = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (chOh[i] && startReq) begin
                        state_d[i] = ST_BUSY;
                        start_d[i] = 1'b1;
                    end else if (chOh[i] && rdResult) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (chOh[i] && (state_q[i] != ST_BUSY)) begin
                if (wrMcand)  mcand_d[i]  = data[OP_W-1:0];
                if (wrMplier) mplier_d[i] = data[OP_W-1:0];
            end
            if (chOh[i] && clrErr) begin
                err_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        irqEn_d = irqEn_q;
        if (wren && irqEnHit) begin
            irqEn_d = '0;
            for (int i = 0; i < NUM_CH && i < 32; i++) irqEn_d[i] = data[i];
        end
        debug_d = (wren && debugHit) ? data : debug_q;
    end

    // Read path samples pre-write state, so a simultaneous write is not reflected in q.
    always_comb begin
        chRd    = '0;
        irqEnRd = '0;
        doneRd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chOh[i]) begin
                case (regSel)
                    2'd0:    chRd = 32'(mcand_q[i]);
                    2'd1:    chRd = 32'(mplier_q[i]);
                    2'd2:    chRd = {29'b0, err_q[i], state_q[i] == ST_BUSY, state_q[i] == ST_DONE};
                    default: chRd = 32'(result_q[i]);
                endcase
            end
        end
        for (int i = 0; i < NUM_CH && i < 32; i++) begin
            irqEnRd[i] = irqEn_q[i];
            doneRd[i]  = doneVec[i];
        end
        rdata_d = rdata_q;
        if (rden) begin
            if (chHit)           rdata_d = chRd;
            else if (irqEnHit)   rdata_d = irqEnRd;
            else if (doneSumHit) rdata_d = doneRd;
            else if (debugHit)   rdata_d = debug_q;
            else                 rdata_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                mcand_q[i]  <= '0;
                mplier_q[i] <= '0;
                result_q[i] <= '0;
            end
            err_q   <= '0;
            start_q <= '0;
            irqEn_q <= '0;
            debug_q <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                mcand_q[i]  <= mcand_d[i];
                mplier_q[i] <= mplier_d[i];
                result_q[i] <= result_d[i];
            end
            err_q   <= err_d;
            start_q <= start_d;
            irqEn_q <= irqEn_d;
            debug_q <= debug_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_multiplicand[i*OP_W +: OP_W] = mcand_q[i];
            ch_multiplier[i*OP_W +: OP_W]   = mplier_q[i];
        end
    end

    assign ch_start = start_q;
    assign q        = rdata_q;
    assign irq      = |(doneVec & irqEn_q);

endmodule

// File: tb/tb_mini_core_accel_cr_mem_param.sv
// Randomised self-checking bench for mini_core_accel_cr_mem_param: a default 8x8 instance
// against a per-channel behavioural model, plus a 1-channel 16-bit instance for the width sweep.
module tb_mini_core_accel_cr_mem_param;

    localparam int          NCH  = 8;
    localparam int          OPW  = 8;
    localparam int          RW   = 2 * OPW;
    localparam logic [31:0] BASE = 32'h00FE_2000;

    logic              Clk, Rst_n;
    logic [31:0]       data, address, q;
    logic              wren, rden, irq;
    logic [NCH*OPW-1:0] mcandOut, mplierOut;
    logic [NCH-1:0]    chStart, chDone;
    logic [NCH*RW-1:0] chResult;

    logic [31:0] bData, bAddress, bQ, bResult;
    logic        bWren, bRden, bIrq;
    logic [15:0] bMcand, bMplier;
    logic [0:0]  bStart, bDone;

    int checks = 0;
    int errors = 0;
    int startCnt  [NCH];
    int expStarts [NCH];
    int bStartCnt = 0;

    logic [7:0]  mMcand [NCH];
    logic [7:0]  mMplier[NCH];
    logic [15:0] mRes   [NCH];
    bit          mBusy  [NCH];
    bit          mDone  [NCH];
    bit          mErr   [NCH];
    logic [7:0]  mIrqEn;

    mini_core_accel_cr_mem_param #(.NUM_CH(NCH), .OP_W(OPW), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .data(data), .address(address), .wren(wren), .rden(rden),
        .q(q), .ch_multiplicand(mcandOut), .ch_multiplier(mplierOut), .ch_start(chStart),
        .ch_done(chDone), .ch_result(chResult), .irq(irq)
    );

    mini_core_accel_cr_mem_param #(.NUM_CH(1), .OP_W(16), .BASE_ADDR(BASE)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .data(bData), .address(bAddress), .wren(bWren), .rden(bRden),
        .q(bQ), .ch_multiplicand(bMcand), .ch_multiplier(bMplier), .ch_start(bStart),
        .ch_done(bDone), .ch_result(bResult), .irq(bIrq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count start pulses in the middle of each cycle.
    always @(negedge Clk) begin
        for (int i = 0; i < NCH; i++) if (chStart[i] === 1'b1) startCnt[i]++;
        if (bStart[0] === 1'b1) bStartCnt++;
    end

    function automatic logic [31:0] chAddr(input int ch, input int r);
        return BASE + 32'(ch * 16 + r * 4);
    endfunction

    function automatic logic expIrq();
        for (int i = 0; i < NCH; i++) if (mDone[i] && mIrqEn[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] expStatus(input int ch);
        return {29'b0, mErr[ch], mBusy[ch], mDone[ch]};
    endfunction

    function automatic logic [7:0] expDoneSum();
        logic [7:0] v;
        for (int i = 0; i < NCH; i++) v[i] = mDone[i];
        return v;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NCH; i++) begin
            mMcand[i] = '0; mMplier[i] = '0; mRes[i] = '0;
            mBusy[i] = 0; mDone[i] = 0; mErr[i] = 0;
        end
        mIrqEn = '0;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        address = a; data = d; wren = 1'b1;
        @(posedge Clk); @(negedge Clk);
        wren = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] v);
        address = a; rden = 1'b1;
        @(posedge Clk); @(negedge Clk);
        rden = 1'b0;
        v = q;
    endtask

    task automatic opWrite(input int ch, input int r, input logic [7:0] v);
        busWrite(chAddr(ch, r), {24'($urandom), v});
        if (mBusy[ch])   mErr[ch] = 1;
        else if (r == 0) mMcand[ch] = v;
        else             mMplier[ch] = v;
    endtask

    task automatic opCtrl(input int ch, input logic [1:0] d, output logic pulse, output logic expPulse);
        busWrite(chAddr(ch, 2), {30'($urandom), d});
        pulse = chStart[ch];
        expPulse = 1'b0;
        if (d[0]) begin
            if (mBusy[ch]) mErr[ch] = 1;
            else begin
                mBusy[ch] = 1; mDone[ch] = 0; expStarts[ch]++; expPulse = 1'b1;
            end
        end
        if (d[1]) mErr[ch] = 0;
    endtask

    task automatic opDone(input int ch);
        logic [15:0] r;
        r = 16'(mMcand[ch]) * 16'(mMplier[ch]);
        chResult = {$urandom, $urandom, $urandom, $urandom};
        chResult[ch*RW +: RW] = r;
        chDone[ch] = 1'b1;
        @(posedge Clk); @(negedge Clk);
        chDone[ch] = 1'b0;
        if (mBusy[ch]) begin
            mBusy[ch] = 0; mDone[ch] = 1; mRes[ch] = r;
        end
    endtask

    task automatic opReadResult(input int ch, output logic [31:0] got, output logic [31:0] exp);
        exp = 32'(mRes[ch]);
        busRead(chAddr(ch, 3), got);
        if (mDone[ch]) mDone[ch] = 0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        resetModel();
        checks++; if (q !== 32'h0) begin errors++; $display("[TB] FAIL reset_q got %h exp 0", q); end
        checks++; if (chStart !== '0) begin errors++; $display("[TB] FAIL reset_start got %h exp 0", chStart); end
        checks++; if ({mcandOut, mplierOut} !== '0) begin errors++; $display("[TB] FAIL reset_operands got %h/%h exp 0", mcandOut, mplierOut); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
        Rst_n = 1'b1;
        @(negedge Clk);
        for (int ch = 0; ch < NCH; ch += 3) begin
            logic [31:0] v;
            busRead(chAddr(ch, 2), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_status ch%0d got %h exp 0", ch, v); end
        end
    endtask

    task automatic test_basic_multiply();
        logic [31:0] v, e;
        logic p, ep;
        opWrite(2, 0, 8'h07);
        opWrite(2, 1, 8'hFA);
        checks++; if (mcandOut[2*OPW +: OPW] !== 8'h07 || mplierOut[2*OPW +: OPW] !== 8'hFA) begin
            errors++; $display("[TB] FAIL basic_operands got %h/%h exp 07/fa", mcandOut[2*OPW +: OPW], mplierOut[2*OPW +: OPW]);
        end
        opCtrl(2, 2'b01, p, ep);
        checks++; if (p !== ep) begin errors++; $display("[TB] FAIL basic_start_pulse got %b exp %b", p, ep); end
        @(negedge Clk);
        checks++; if (chStart[2] !== 1'b0) begin errors++; $display("[TB] FAIL basic_start_width got %b exp 0", chStart[2]); end
        opDone(2);
        busRead(chAddr(2, 2), v);
        checks++; if (v !== expStatus(2) || v !== 32'h1) begin errors++; $display("[TB] FAIL basic_status_done got %h exp 1", v); end
        opReadResult(2, v, e);
        checks++; if (v !== e || v !== 32'h0000_06D6) begin errors++; $display("[TB] FAIL basic_result got %h exp 000006d6", v); end
        busRead(chAddr(2, 2), v);
        checks++; if (v !== expStatus(2)) begin errors++; $display("[TB] FAIL basic_status_clear got %h exp %h", v, expStatus(2)); end
        checks++; if (startCnt[2] !== expStarts[2]) begin errors++; $display("[TB] FAIL basic_start_count got %0d exp %0d", startCnt[2], expStarts[2]); end
    endtask

    task automatic test_busy_protection();
        logic [31:0] v, e;
        logic p, ep;
        logic [7:0] a;
        a = 8'($urandom_range(1, 200));
        opWrite(0, 0, a);
        opWrite(0, 1, 8'($urandom));
        opCtrl(0, 2'b01, p, ep);
        opWrite(0, 0, 8'h55);
        checks++; if (mcandOut[0 +: OPW] !== a) begin errors++; $display("[TB] FAIL busy_operand_locked got %h exp %h", mcandOut[0 +: OPW], a); end
        opCtrl(0, 2'b01, p, ep);
        checks++; if (p !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_restart got %b exp 0", p); end
        busRead(chAddr(0, 2), v);
        checks++; if (v !== expStatus(0) || v !== 32'h6) begin errors++; $display("[TB] FAIL busy_status_err got %h exp 6", v); end
        opCtrl(0, 2'b10, p, ep);
        busRead(chAddr(0, 2), v);
        checks++; if (v !== expStatus(0) || v !== 32'h2) begin errors++; $display("[TB] FAIL busy_clear_err got %h exp 2", v); end
        opDone(0);
        opReadResult(0, v, e);
        checks++; if (v !== e) begin errors++; $display("[TB] FAIL busy_result got %h exp %h", v, e); end
        checks++; if (startCnt[0] !== expStarts[0]) begin errors++; $display("[TB] FAIL busy_start_count got %0d exp %0d", startCnt[0], expStarts[0]); end
    endtask

    task automatic test_collision();
        logic [31:0] v, e;
        logic p, ep;
        logic [15:0] r;
        opWrite(5, 0, 8'($urandom));
        opWrite(5, 1, 8'($urandom));
        opCtrl(5, 2'b01, p, ep);
        r = 16'(mMcand[5]) * 16'(mMplier[5]);
        chResult[5*RW +: RW] = r;
        chDone[5] = 1'b1;
        address = chAddr(5, 2); data = 32'h1; wren = 1'b1;
        @(posedge Clk); @(negedge Clk);
        wren = 1'b0; chDone[5] = 1'b0;
        mBusy[5] = 0; mDone[5] = 1; mRes[5] = r; mErr[5] = 1;
        checks++; if (chStart[5] !== 1'b0) begin errors++; $display("[TB] FAIL collision_no_pulse got %b exp 0", chStart[5]); end
        busRead(chAddr(5, 2), v);
        checks++; if (v !== expStatus(5) || v !== 32'h5) begin errors++; $display("[TB] FAIL collision_status got %h exp 5", v); end
        checks++; if (startCnt[5] !== 1) begin errors++; $display("[TB] FAIL collision_start_count got %0d exp 1", startCnt[5]); end
        opReadResult(5, v, e);
        checks++; if (v !== e) begin errors++; $display("[TB] FAIL collision_result got %h exp %h", v, e); end
        opCtrl(5, 2'b10, p, ep);
    endtask

    task automatic test_irq();
        logic [31:0] v, e;
        logic p, ep;
        busWrite(BASE + 32'h800, 32'h0A);
        mIrqEn = 8'h0A;
        for (int ch = 1; ch <= 3; ch += 2) begin
            opWrite(ch, 0, 8'($urandom));
            opWrite(ch, 1, 8'($urandom));
            opCtrl(ch, 2'b01, p, ep);
            opDone(ch);
        end
        checks++; if (irq !== expIrq() || irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set got %b exp 1", irq); end
        busRead(BASE + 32'h804, v);
        checks++; if (v !== 32'(expDoneSum()) || v !== 32'h0A) begin errors++; $display("[TB] FAIL irq_done_sum got %h exp 0a", v); end
        opReadResult(1, v, e);
        checks++; if (irq !== expIrq()) begin errors++; $display("[TB] FAIL irq_partial got %b exp %b", irq, expIrq()); end
        opReadResult(3, v, e);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_cleared got %b exp 0", irq); end
        opCtrl(0, 2'b01, p, ep);
        opDone(0);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked got %b exp 0", irq); end
        busRead(BASE + 32'h804, v);
        checks++; if (v !== 32'(expDoneSum())) begin errors++; $display("[TB] FAIL irq_done_sum_ch0 got %h exp %h", v, expDoneSum()); end
        opReadResult(0, v, e);
        checks++; if (v !== e) begin errors++; $display("[TB] FAIL irq_result_ch0 got %h exp %h", v, e); end
    endtask

    task automatic test_unmapped_debug();
        logic [31:0] v, d2;
        busWrite(BASE + 32'h7F0, 32'hFFFF_FFFF);
        busRead(BASE + 32'h7F0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read got %h exp 0", v); end
        busWrite(BASE + 32'h808, 32'hDEAD_BEEF);
        busRead(BASE + 32'h808, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL debug_roundtrip got %h exp deadbeef", v); end
        busRead(BASE + 32'h1808, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL outside_window got %h exp 0", v); end
        busRead(BASE + 32'h808, v);
        repeat (3) @(negedge Clk);
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL q_hold got %h exp deadbeef", q); end
        d2 = $urandom;
        address = BASE + 32'h808; data = d2; wren = 1'b1; rden = 1'b1;
        @(posedge Clk); @(negedge Clk);
        wren = 1'b0; rden = 1'b0;
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rw_same_cycle got %h exp deadbeef", q); end
        busRead(BASE + 32'h808, v);
        checks++; if (v !== d2) begin errors++; $display("[TB] FAIL rw_written got %h exp %h", v, d2); end
    endtask

    task automatic bBus(input logic [31:0] a, input logic [31:0] d, input logic w, output logic [31:0] v);
        bAddress = a; bData = d; bWren = w; bRden = ~w;
        @(posedge Clk); @(negedge Clk);
        bWren = 1'b0; bRden = 1'b0;
        v = bQ;
    endtask

    task automatic test_param_sweep();
        logic [31:0] v;
        bBus(BASE + 32'h0, 32'h0000_FFFF, 1'b1, v);
        bBus(BASE + 32'h4, 32'hABCD_FFFF, 1'b1, v);
        bBus(BASE + 32'h8, 32'h1, 1'b1, v);
        checks++; if (bStart[0] !== 1'b1) begin errors++; $display("[TB] FAIL sweep_start got %b exp 1", bStart[0]); end
        bResult = 32'hFFFE_0001; bDone = 1'b1;
        @(posedge Clk); @(negedge Clk);
        bDone = 1'b0; bResult = 32'h0;
        bBus(BASE + 32'h8, 32'h0, 1'b0, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL sweep_status got %h exp 1", v); end
        bBus(BASE + 32'hC, 32'h0, 1'b0, v);
        checks++; if (v !== 32'hFFFE_0001) begin errors++; $display("[TB] FAIL sweep_result got %h exp fffe0001", v); end
        bBus(BASE + 32'h8, 32'h0, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL sweep_status_clear got %h exp 0", v); end
        bBus(BASE + 32'h10, 32'h0, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL sweep_unmapped got %h exp 0", v); end
        checks++; if (bStartCnt !== 1) begin errors++; $display("[TB] FAIL sweep_start_count got %0d exp 1", bStartCnt); end
    endtask

    task automatic test_random();
        logic [31:0] v, e;
        logic p, ep;
        for (int n = 0; n < 400; n++) begin
            int ch, op;
            ch = $urandom_range(0, NCH - 1);
            op = $urandom_range(0, 6);
            case (op)
                0, 1: opWrite(ch, op, 8'($urandom));
                2: begin
                    opCtrl(ch, 2'($urandom), p, ep);
                    checks++; if (p !== ep) begin errors++; $display("[TB] FAIL rand_start ch%0d got %b exp %b", ch, p, ep); end
                end
                3: opDone(ch);
                4: begin
                    e = expStatus(ch);
                    busRead(chAddr(ch, 2), v);
                    checks++; if (v !== e) begin errors++; $display("[TB] FAIL rand_status ch%0d got %h exp %h", ch, v, e); end
                end
                5: begin
                    opReadResult(ch, v, e);
                    checks++; if (v !== e) begin errors++; $display("[TB] FAIL rand_result ch%0d got %h exp %h", ch, v, e); end
                end
                default: begin
                    v = $urandom;
                    busWrite(BASE + 32'h800, v);
                    mIrqEn = v[7:0];
                end
            endcase
            checks++; if (mcandOut[ch*OPW +: OPW] !== mMcand[ch] || mplierOut[ch*OPW +: OPW] !== mMplier[ch]) begin
                errors++; $display("[TB] FAIL rand_operands ch%0d got %h/%h exp %h/%h", ch,
                    mcandOut[ch*OPW +: OPW], mplierOut[ch*OPW +: OPW], mMcand[ch], mMplier[ch]);
            end
            checks++; if (irq !== expIrq()) begin errors++; $display("[TB] FAIL rand_irq got %b exp %b", irq, expIrq()); end
        end
        busRead(BASE + 32'h804, v);
        checks++; if (v !== 32'(expDoneSum())) begin errors++; $display("[TB] FAIL rand_done_sum got %h exp %h", v, expDoneSum()); end
        @(negedge Clk);
        for (int i = 0; i < NCH; i++) begin
            checks++; if (startCnt[i] !== expStarts[i]) begin errors++; $display("[TB] FAIL rand_start_count ch%0d got %0d exp %0d", i, startCnt[i], expStarts[i]); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v, e;
        logic p, ep;
        busWrite(BASE + 32'h800, 32'hFF);
        mIrqEn = 8'hFF;
        opWrite(6, 0, 8'h12); opWrite(6, 1, 8'h34);
        opCtrl(6, 2'b01, p, ep);
        opDone(6);
        opWrite(4, 0, 8'h9A); opWrite(4, 1, 8'hBC);
        opCtrl(4, 2'b01, p, ep);
        busWrite(BASE + 32'h808, 32'h1234_5678);
        busRead(BASE + 32'h808, v);
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_irq got %b exp 1", irq); end
        #2 Rst_n = 1'b0;
        #1;
        resetModel();
        checks++; if (q !== 32'h0 || irq !== 1'b0 || chStart !== '0) begin
            errors++; $display("[TB] FAIL midrst_outputs got q=%h irq=%b start=%h exp 0", q, irq, chStart);
        end
        checks++; if ({mcandOut, mplierOut} !== '0) begin errors++; $display("[TB] FAIL midrst_operands got %h/%h exp 0", mcandOut, mplierOut); end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        opDone(4);
        busRead(chAddr(4, 2), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midrst_status got %h exp 0", v); end
        opReadResult(4, v, e);
        checks++; if (v !== 32'h0 || v !== e) begin errors++; $display("[TB] FAIL midrst_result got %h exp 0", v); end
        busRead(BASE + 32'h808, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midrst_debug got %h exp 0", v); end
        busRead(BASE + 32'h800, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midrst_irq_en got %h exp 0", v); end
    endtask

    initial begin
        data = '0; address = '0; wren = 1'b0; rden = 1'b0;
        chDone = '0; chResult = '0;
        bData = '0; bAddress = '0; bWren = 1'b0; bRden = 1'b0; bDone = '0; bResult = '0;
        for (int i = 0; i < NCH; i++) begin startCnt[i] = 0; expStarts[i] = 0; end
        test_reset();
        test_basic_multiply();
        test_busy_protection();
        test_collision();
        test_irq();
        test_unmapped_debug();
        test_param_sweep();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mini_core_accel_cr_mem_param.md
# mini_core_accel_cr_mem_param

Parametrised control-register (CR) block between the mini_core data-memory port and a farm of NUM_CH multiplier accelerators. It extends the flat int8 CR map with several capabilities:
- configurable operand width and channel count;
- an explicit start pulse and a per-channel IDLE/BUSY/DONE state machine;
- sticky done and error bits;
- read-to-clear results;
- a maskable interrupt.

The core sees a memory-mapped window at BASE_ADDR; the accelerators see registered operands, start pulses, and done/result returns.

## Interface
- NUM_CH, 8, number of accelerator channels (1..64)
- OP_W, 8, operand width in bits (2..16); result width is 2*OP_W
- BASE_ADDR, 32'h00FE_2000, byte base of the CR window (4 KB aligned)

- Clk  in  1  clock; all state on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- data  in  32  core write data
- address  in  32  core byte address
- wren  in  1  core write strobe (single cycle)
- rden  in  1  core read strobe (single cycle)
- q  out  32  registered read data
- ch_multiplicand  out  NUM_CH*OP_W  per-channel multiplicand, channel i at [i*OP_W +: OP_W]
- ch_multiplier  out  NUM_CH*OP_W  per-channel multiplier
- ch_start  out  NUM_CH  one-cycle start pulse per channel
- ch_done  in  NUM_CH  per-channel completion pulse from the accelerator
- ch_result  in  NUM_CH*2*OP_W  per-channel product, valid when ch_done is high
- irq  out  1  level interrupt = |(done_vec & irq_en)

## Operation
**Address decode**
- Hit when address[31:12] == BASE_ADDR[31:12].
- off = address[11:0].
- Channel region: off < NUM_CH*16, with ch = off[9:4] and reg = off[3:2].
- Global region: off 0x800..0x808.
- Everything else is unmapped: writes are ignored and reads return 0.

**Channel registers**
- 0x0 MCAND: RW, data[OP_W-1:0].
- 0x4 MPLIER: RW, data[OP_W-1:0].
- 0x8 CTRL/STATUS:
  - Write: bit0 = start, bit1 = clear err.
  - Read: {29'b0, err, busy, done}.
- 0xC RESULT: RO, returns the captured result zero-extended to 32 bits.

**Global registers**
- 0x800 IRQ_EN: RW, NUM_CH bits.
- 0x804 DONE_SUM: RO, done bit of every channel.
- 0x808 DEBUG: RW, 32 bits.

**Per-channel FSM**
- Reset state is IDLE.
- IDLE or DONE + start write → BUSY:
  - done clears;
  - ch_start pulses for one cycle.
- BUSY + ch_done=1 → DONE: ch_result is captured into the result register.
- DONE + read of RESULT → IDLE: done clears and q returns the result.
- In BUSY, the following are ignored and set sticky err:
  - a start write;
  - a write to MCAND or MPLIER (operands stay locked).
- CTRL write with bit1=1 clears err. If bit0 is also set, the start is evaluated against the current state as above, and clear-err takes priority over a new err in the same write.
- ch_done outside BUSY is ignored (no capture, no err).

**Other rules**
- Simultaneous events in BUSY: if ch_done and a start write arrive in the same cycle, done wins (goes to DONE) and the start is dropped with err=1.
- Reading RESULT in IDLE or BUSY returns the last captured value and causes no state change.
- ch_multiplicand and ch_multiplier are driven directly from the flops.
- Only one register is accessed per cycle. If wren and rden are both high, the write is performed and the read returns pre-write contents.

## Timing
**Reset values:** q=0, ch_start=0, all operands/results/irq_en/debug=0, all FSMs IDLE, irq=0.

**Latencies**
- Write: wren in cycle N → register updated at edge N+1 and visible on the outputs in cycle N+1.
- Start pulse: start write in cycle N → ch_start[ch]=1 in cycle N+1 only.
- Read: rden in cycle N → q valid from cycle N+1. q holds its value while rden=0.
- Done capture: ch_done in cycle N → status done=1 and irq updated in cycle N+1. The earliest RESULT read returning the new value is issued in cycle N+1.
- Read-to-clear: the state change takes effect at the same edge that loads q.

**Reset mid-operation:** asserting Rst_n low immediately forces all of the above to reset values. A ch_done arriving after release is ignored because the channel is IDLE.

## Test plan
- **Basic multiply:** write MCAND[2]=0x07 and MPLIER[2]=0xFA (OP_W=8), then CTRL[2]=1. Required response:
  - ch_start[2] pulses once, one cycle after the write;
  - return ch_done[2] with ch_result=0x06D6 → STATUS reads 0x1 and RESULT reads 0x000006D6;
  - a following STATUS read gives 0x0.
- **Busy protection:** while ch 0 is BUSY, write MCAND[0]=0x55 and CTRL[0]=1. Required response:
  - operand output unchanged;
  - no second ch_start;
  - STATUS=0x6;
  - then CTRL[0]=0x2 gives STATUS=0x2.
- **Collision:** in a BUSY cycle, assert ch_done[5] and write CTRL[5]=1 simultaneously → STATUS[5]=0x5 and exactly one ch_start was issued.
- **Interrupt and summary:** IRQ_EN=0x0A; complete ch 1 and ch 3 → irq=1 and DONE_SUM=0x0A. Read RESULT[1] and RESULT[3] → irq=0. Completing ch 0 alone leaves irq=0.
- **Param sweep:** run NUM_CH=1/OP_W=16 with 0xFFFF*0xFFFF → RESULT=0xFFFE0001. Also check:
  - unmapped read (off 0x7F0) returns 0;
  - DEBUG write/read of 0xDEADBEEF round-trips.
- **Reset mid-operation:** drive Rst_n low while ch 4 is BUSY → all outputs return to reset values. A ch_done[4] after release leaves STATUS=0x0 and RESULT=0.
